// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
//   - uart_state_t    : receive FSM state encoding (2 bits)
//   - UART_DATA_BITS  : default data bits per frame
//   - UART_OVERSAMPLE : default baud-tick count per bit period; the tick
//                       divisor and the transmitter are built from the same
//                       value so both ends of the link agree.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
// RESET_VAL sets the value both flops hold in reset, matching the idle level
// of the signal being synchronized. This keeps a spurious edge from appearing
// when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q update together at the
  // edge, giving two real flop stages. Blocking ones would collapse them into
  // one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit,
// no parity. The line is oversampled with the shared baud tick, at OVERSAMPLE
// ticks per bit.
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   tick        : oversample enable, one clk wide per pulse (may be held high)
//   rx          : asynchronous serial input, idles high
//   data        : last correctly framed character
//   data_valid  : one-cycle pulse when data updates
//   frame_error : one-cycle pulse when the stop bit samples low
//   busy        : high whenever the FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // The start bit is confirmed half a bit in. Every later sample is a full bit
  // after the previous one, so all data and stop samples land mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state,   state_n;
  logic [CNT_W-1:0]     cnt,     cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg,   shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 data_valid_n;
  logic                 frame_error_n;

  // rx idles high, so the synchronizer resets to 1. Releasing reset then does
  // not look like a start edge.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      data        <= data_n;
      data_valid  <= data_valid_n;
      frame_error <= frame_error_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so a
    // path that leaves a signal untouched holds its value and infers no latch.
    // The pulse outputs default to 0, which keeps them one cycle wide.
    state_n       = state;
    cnt_n         = cnt;
    bit_idx_n     = bit_idx;
    shreg_n       = shreg;
    data_n        = data;
    data_valid_n  = 1'b0;
    frame_error_n = 1'b0;

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            cnt_n   = '0;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt_n     = '0;
            bit_idx_n = '0;
            // A line that is already high again at mid-start was a glitch.
            // Drop it without raising any flag.
            state_n   = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            // Right shift: the first bit received ends up in the LSB.
            shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
            cnt_n     = '0;
            bit_idx_n = bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
              state_n = ST_STOP;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            // Back in IDLE at mid-stop, so a start edge that follows
            // immediately is still caught half a bit later.
            cnt_n   = '0;
            state_n = ST_IDLE;
            if (rx_s) begin
              data_n       = shreg;
              data_valid_n = 1'b1;
            end else begin
              frame_error_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine for the external-communication path. It oversamples the serial `rx` line using the shared baud `tick` enable, recovers framed characters (1 start bit, DATA_BITS data bits LSB-first, 1 stop bit, no parity) and presents each one as a parallel byte with a single-cycle valid strobe. The block is the receiving end of the UART link and shares the baud-tick generator with the transmit side. The tick generator must be configured for OVERSAMPLE ticks per bit.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, range 5..9.
- `OVERSAMPLE`, default 16: ticks per bit period. Must be even and at least 4.

Ports (one clock; reset is synchronous and active-high):
- `clk`: input, 1 bit. Rising-edge system clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `tick`: input, 1 bit. Oversample enable, one `clk` wide per pulse. May be held high continuously.
- `rx`: input, 1 bit. Asynchronous serial line; idles high.
- `data`: output, DATA_BITS bits. Last correctly framed character.
- `data_valid`: output, 1 bit. One-cycle pulse when `data` updates.
- `frame_error`: output, 1 bit. One-cycle pulse when the stop bit samples low.
- `busy`: output, 1 bit. High whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Sample counter `cnt` is clog2(OVERSAMPLE) bits wide. Bit index `bit_idx` is clog2(DATA_BITS+1) bits wide.
- `cnt` and the FSM advance only on cycles where `tick`=1. With `tick`=0 all state holds.
- FSM states:
  - IDLE:
    - On tick with `rx_s`=0, go to START with `cnt`=0.
  - START:
    - On each tick, `cnt`++.
    - When `cnt`==OVERSAMPLE/2−1 and `rx_s`=0, go to DATA with `cnt`=0 and `bit_idx`=0. This is the mid-start-bit check.
    - If `rx_s`=1 at that point, treat it as a glitch and return to IDLE. Raise no flags.
  - DATA:
    - On each tick, `cnt`++.
    - When `cnt`==OVERSAMPLE−1: shift `rx_s` into the MSB of the DATA_BITS shift register (right shift, so the bit lands LSB-first), set `cnt`=0, `bit_idx`++.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP:
    - On the tick where `cnt`==OVERSAMPLE−1, sample `rx_s`.
    - If 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
    - If 0: pulse `frame_error`, leave `data` unchanged, go to IDLE.
- Sampling the stop bit mid-bit and returning to IDLE at once allows back-to-back frames: a start edge half a bit after the stop sample is detected.
- After a framing error with the line held low (break), IDLE re-detects a start on the next tick. This behaviour is accepted.
- Reset values: `data`=0, `data_valid`=0, `frame_error`=0, `busy`=0, FSM=IDLE, `cnt`=0, `bit_idx`=0, shift register=0.
- Reset mid-frame discards the partial character. The next frame is received normally.

## Timing
- `data_valid` and `frame_error` are registered. They assert in the `clk` cycle after the stop-sample tick, last exactly one cycle, and are never high together.
- `data` changes only in the same cycle `data_valid` rises and holds until the next valid frame.
- Latency from the first low `rx_s` tick to `data_valid` is OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks, plus 1 `clk`. Add 2 `clk` of synchronizer delay measured from `rx`.
- `busy` rises the cycle after start detection and falls the cycle after the stop sample.
- No back-pressure. The consumer must take `data` within one frame time.
- If `reset` and `tick` occur in the same cycle, `reset` wins.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE/START/DATA/STOP), 2-bit;
  - default constants UART_DATA_BITS=8 and UART_OVERSAMPLE=16, so the transmitter and the tick divisor match.
- One natural sub-module: `sync_2ff`, a 2-flop synchronizer with a parameterised reset value (1 here). It is reused for other asynchronous inputs.

## Test plan
- Frame 0x55. Setup: DATA_BITS=8, OVERSAMPLE=16, tick every 5 clk (80 clk/bit). Expected: `data`=0x55, one `data_valid` pulse about 760 clk after the falling edge, `frame_error`=0 throughout.
- Start glitch: `rx` low for 3 ticks then high. Expected: no `data_valid`, no `frame_error`, `busy` returns to 0, FSM back in IDLE.
- Bad stop: frame 0xA3 with the stop bit driven 0. Expected: one `frame_error` pulse, no `data_valid`, `data` keeps its previous value.
- Back-to-back: frames 0x00 then 0xFF with no idle gap. Expected: two `data_valid` pulses, with values 0x00 then 0xFF.
- Mid-frame reset: `reset` asserted for 1 cycle during bit 4 of 0x12, then frame 0x3C sent. Expected: all outputs 0 after reset, no pulse for the 0x12 frame, then `data`=0x3C with a valid pulse.
- Tick held high: `tick`=1 constantly (16 clk/bit), frame 0xC3. Expected: `data`=0xC3, one `data_valid` pulse.
